// File: rtl/alu1_sequencer_pkg.sv
// rtl/alu1_sequencer_pkg.sv - shared opcode, width and state definitions for the alu1 sequencer
package alu1_sequencer_pkg;

    localparam int ALU_W = 6;

    localparam logic [1:0] OP_INC_ADD = 2'b00;
    localparam logic [1:0] OP_PASS    = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_SUB     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu1_sequencer_alu1.sv
// rtl/alu1_sequencer_alu1.sv - combinational 6-bit alu1 datapath
// ports: a, b operands; c opcode (00 a+b+1, 01 a, 10 a&b, 11 a-b); f result (mod 64)
module alu1
    import alu1_sequencer_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [1:0]       c,
    output logic [ALU_W-1:0] f
);

    always_comb begin
        f = '0;
        case (c)
            OP_INC_ADD: f = a + b + ALU_W'(1);
            OP_PASS:    f = a;
            OP_AND:     f = a & b;
            OP_SUB:     f = a - b;
            default:    f = '0;
        endcase
    end

endmodule

// File: rtl/alu1_sequencer.sv
// rtl/alu1_sequencer.sv - command-driven accumulator sequencer around alu1
// ports: clk, rst_n (async, active-low)
//        cmd_valid/cmd_ready/cmd_load/cmd_op/cmd_b/cmd_cnt : command handshake
//        res_valid/res_ready/res_data/res_zero/res_neg/res_ovf : result handshake
//        busy : high whenever not idle
module alu1_sequencer
    import alu1_sequencer_pkg::*;
#(
    parameter int CW = 3,
    parameter int W  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [1:0]    cmd_op,
    input  logic [W-1:0]  cmd_b,
    input  logic [CW-1:0] cmd_cnt,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic          res_zero,
    output logic          res_neg,
    output logic          res_ovf,
    output logic          busy
);

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  b_reg;
    logic [1:0]    op_reg;
    logic [CW-1:0] rem;
    logic          ovf;
    logic [W-1:0]  alu_f;
    logic          ovf_now;

    alu1 u_alu1 (
        .a (acc),
        .b (b_reg),
        .c (op_reg),
        .f (alu_f)
    );

    // Signed overflow from sign bits only: add-with-carry overflows when both
    // operands share a sign the result lacks; subtract when operand signs differ
    // and the result sign departs from a.
    always_comb begin
        ovf_now = 1'b0;
        case (op_reg)
            OP_INC_ADD: ovf_now = (acc[W-1] == b_reg[W-1]) && (alu_f[W-1] != acc[W-1]);
            OP_SUB:     ovf_now = (acc[W-1] != b_reg[W-1]) && (alu_f[W-1] != acc[W-1]);
            default:    ovf_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            rem    <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        ovf <= 1'b0;
                        if (cmd_load) begin
                            acc   <= cmd_b;
                            state <= ST_DONE;
                        end else begin
                            op_reg <= cmd_op;
                            b_reg  <= cmd_b;
                            rem    <= cmd_cnt;
                            state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    acc <= alu_f;
                    ovf <= ovf | ovf_now;
                    if (rem == '0) begin
                        state <= ST_DONE;
                    end else begin
                        rem <= rem - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign res_data  = acc;
    assign res_zero  = (acc == '0);
    assign res_neg   = acc[W-1];
    assign res_ovf   = ovf;

endmodule
